// File: rtl/header_pin_exerciser_if.sv
// Host/header-side signal bundle for header_pin_exerciser.
// The slave modport is the exerciser itself; the master modport is whoever
// drives run/mode/clr_err and presents the header pin readback.
interface header_pin_exerciser_if #(
   parameter int NPINS    = 56,
   parameter int ERRCNT_W = 8
);
   localparam int POS_W = $clog2(NPINS);

   logic                 run;
   logic [1:0]           mode;
   logic                 clr_err;
   logic [NPINS-1:0]     pin_in;
   logic [NPINS-1:0]     pin_out;
   logic [NPINS-1:0]     pin_oe;
   logic [POS_W-1:0]     pos;
   logic                 step;
   logic                 busy;
   logic [NPINS/2-1:0]   err_flags;
   logic [ERRCNT_W-1:0]  err_cnt;

   modport master (
      output run, mode, clr_err, pin_in,
      input  pin_out, pin_oe, pos, step, busy, err_flags, err_cnt
   );

   modport slave (
      input  run, mode, clr_err, pin_in,
      output pin_out, pin_oe, pos, step, busy, err_flags, err_cnt
   );
endinterface

// File: rtl/header_pin_exerciser.sv
// Header pin bring-up engine: walks 1/0, counts, or drives even pins and
// reads them back on the odd neighbour through loopback jumpers.
// Each pattern position dwells 2**DIV_W cycles in DRIVE plus SETTLE1,
// SETTLE2 and CHECK; the pattern advances as CHECK is left.
module header_pin_exerciser #(
   parameter int NPINS    = 56,
   parameter int DIV_W    = 20,
   parameter int ERRCNT_W = 8
) (
   input  logic                  gck,
   input  logic                  gsr,
   header_pin_exerciser_if.slave bus
);
   localparam int NPAIRS = NPINS / 2;
   localparam int POS_W  = $clog2(NPINS);

   localparam logic [1:0] MODE_WALK1 = 2'b00;
   localparam logic [1:0] MODE_WALK0 = 2'b01;
   localparam logic [1:0] MODE_COUNT = 2'b10;
   localparam logic [1:0] MODE_LOOP  = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DRIVE,
      ST_SETTLE1,
      ST_SETTLE2,
      ST_CHECK
   } state_t;

   state_t                state_q, state_d;
   logic [DIV_W-1:0]      presc_q, presc_d;
   logic [1:0]            mode_q, mode_d;
   logic [POS_W-1:0]      pos_q, pos_d;
   logic [NPINS-1:0]      cnt_q, cnt_d;
   logic [NPINS-1:0]      sync1_q, sync2_q;
   logic [NPAIRS-1:0]     flags_q, flags_d;
   logic [ERRCNT_W-1:0]   errc_q, errc_d;
   logic                  step_q, step_d;
   logic                  busy_q, busy_d;

   logic                  advance;
   logic                  do_check;
   logic [NPINS-1:0]      onehot;
   logic [NPINS-1:0]      loop_out;
   logic [NPINS-1:0]      pat_out;
   logic [NPINS-1:0]      pat_oe;
   logic [NPAIRS-1:0]     mismatch;
   logic [NPAIRS-1:0]     unused_even_sync;

   assign onehot = NPINS'(1) << pos_q;

   // Per pair: even pin carries the walking 1, odd pin is the readback.
   // Even-pin readback is never checked since those pins are driven by us.
   genvar gi;
   generate
      for (gi = 0; gi < NPAIRS; gi++) begin : g_pair
         assign loop_out[2*gi]     = (pos_q == POS_W'(gi));
         assign loop_out[2*gi+1]   = 1'b0;
         assign mismatch[gi]       = sync2_q[2*gi+1] != loop_out[2*gi];
         assign unused_even_sync[gi] = sync2_q[2*gi];
      end
   endgenerate

   // Pattern presented on the header; pins float whenever idle.
   always_comb begin
      pat_out = '0;
      pat_oe  = '0;
      if (state_q != ST_IDLE) begin
         case (mode_q)
            MODE_WALK1: begin pat_oe = '1; pat_out = onehot;   end
            MODE_WALK0: begin pat_oe = '1; pat_out = ~onehot;  end
            MODE_COUNT: begin pat_oe = '1; pat_out = cnt_q;    end
            default:    begin pat_oe = {NPAIRS{2'b01}}; pat_out = loop_out; end
         endcase
      end
   end

   // Sequencer next state, pattern advance and error logging.
   always_comb begin
      state_d  = state_q;
      presc_d  = presc_q;
      mode_d   = mode_q;
      pos_d    = pos_q;
      cnt_d    = cnt_q;
      step_d   = 1'b0;
      advance  = 1'b0;
      do_check = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (bus.run) begin
               mode_d  = bus.mode;
               presc_d = '0;
               state_d = ST_DRIVE;
            end
         end
         ST_DRIVE: begin
            if (presc_q == '1) begin
               presc_d = '0;
               state_d = ST_SETTLE1;
            end else begin
               presc_d = presc_q + DIV_W'(1);
            end
         end
         ST_SETTLE1: state_d = ST_SETTLE2;
         ST_SETTLE2: state_d = ST_CHECK;
         ST_CHECK: begin
            do_check = (mode_q == MODE_LOOP);
            advance  = 1'b1;
            step_d   = 1'b1;
            state_d  = ST_DRIVE;
         end
         default: state_d = ST_IDLE;
      endcase

      // Dropping run aborts the current position without advancing it.
      if (state_q != ST_IDLE && !bus.run) begin
         state_d  = ST_IDLE;
         step_d   = 1'b0;
         advance  = 1'b0;
         do_check = 1'b0;
      end

      if (advance) begin
         case (mode_q)
            MODE_WALK1, MODE_WALK0:
               pos_d = (pos_q == POS_W'(NPINS-1)) ? '0 : pos_q + POS_W'(1);
            MODE_COUNT:
               cnt_d = cnt_q + NPINS'(1);
            default:
               pos_d = (pos_q >= POS_W'(NPAIRS-1)) ? '0 : pos_q + POS_W'(1);
         endcase
      end

      // Clear first, so a mismatch in the same cycle still gets recorded.
      flags_d = bus.clr_err ? '0 : flags_q;
      errc_d  = bus.clr_err ? '0 : errc_q;
      if (do_check) begin
         flags_d = flags_d | mismatch;
         if ((|mismatch) && (errc_d != '1))
            errc_d = errc_d + ERRCNT_W'(1);
      end

      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers plus the pin_in synchroniser.
   always_ff @(posedge gck) begin
      if (gsr) begin
         state_q <= ST_IDLE;
         presc_q <= '0;
         mode_q  <= '0;
         pos_q   <= '0;
         cnt_q   <= '0;
         sync1_q <= '0;
         sync2_q <= '0;
         flags_q <= '0;
         errc_q  <= '0;
         step_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         presc_q <= presc_d;
         mode_q  <= mode_d;
         pos_q   <= pos_d;
         cnt_q   <= cnt_d;
         sync1_q <= bus.pin_in;
         sync2_q <= sync1_q;
         flags_q <= flags_d;
         errc_q  <= errc_d;
         step_q  <= step_d;
         busy_q  <= busy_d;
      end
   end

   assign bus.pin_out   = pat_out;
   assign bus.pin_oe    = pat_oe;
   assign bus.pos       = pos_q;
   assign bus.step      = step_q;
   assign bus.busy      = busy_q;
   assign bus.err_flags = flags_q;
   assign bus.err_cnt   = errc_q;
endmodule

// File: tb/tb_header_pin_exerciser.sv
// Bench for header_pin_exerciser with NPINS=8, DIV_W=2 (7-cycle dwell),
// ERRCNT_W=2. A dwell-counter model is compared every cycle; directed
// literal expectations pin the model at key points.
module tb_header_pin_exerciser;
   localparam int NP     = 8;
   localparam int DWELL  = 7;
   localparam int ERRMAX = 3;

   logic gck;
   logic gsr;
   logic stuck3;
   logic [NP-1:0] pin_in_v;

   int n_tests = 0;
   int n_fail  = 0;

   header_pin_exerciser_if #(.NPINS(NP), .ERRCNT_W(2)) bus ();

   header_pin_exerciser #(.NPINS(NP), .DIV_W(2), .ERRCNT_W(2)) dut (
      .gck (gck),
      .gsr (gsr),
      .bus (bus)
   );

   initial gck = 1'b0;
   always #5 gck = ~gck;

   // Ideal jumpers from each even pin to its odd neighbour, optional pin 3 fault.
   always_comb begin
      pin_in_v = '0;
      for (int k = 0; k < NP/2; k++) pin_in_v[2*k+1] = bus.pin_out[2*k];
      if (stuck3) pin_in_v[3] = 1'b0;
   end
   assign bus.pin_in = pin_in_v;

   // ---------------- behavioural model ----------------
   bit          m_valid = 0;
   bit          m_busy, m_step;
   logic [1:0]  m_mode;
   int          m_pos, m_dwell, m_errc;
   logic [7:0]  m_cnt, m_sync1, m_sync2, m_cap;
   logic [3:0]  m_flags;

   function automatic void model_pins(output logic [7:0] o, output logic [7:0] oe);
      o  = 8'h00;
      oe = 8'h00;
      if (m_busy) begin
         case (m_mode)
            2'b00: begin oe = 8'hFF; o = 8'h01 << m_pos;    end
            2'b01: begin oe = 8'hFF; o = ~(8'h01 << m_pos); end
            2'b10: begin oe = 8'hFF; o = m_cnt;             end
            default: begin oe = 8'h55; o = 8'h01 << (2*m_pos); end
         endcase
      end
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic model_step();
      logic [7:0] eo, eoe;
      logic [3:0] mm;
      bit         do_chk;
      if (gsr) begin
         m_valid = 1; m_busy = 0; m_step = 0; m_mode = 0; m_pos = 0; m_dwell = 0;
         m_errc = 0; m_cnt = 0; m_sync1 = 0; m_sync2 = 0; m_flags = 0;
      end else begin
         mm = 4'h0;
         do_chk = m_busy && bus.run && (m_dwell == DWELL-1);
         if (do_chk && m_mode == 2'b11) begin
            model_pins(eo, eoe);
            for (int k = 0; k < NP/2; k++) mm[k] = (m_sync2[2*k+1] != eo[2*k]);
         end
         if (bus.clr_err) begin m_flags = 0; m_errc = 0; end
         m_flags = m_flags | mm;
         if (mm != 0 && m_errc < ERRMAX) m_errc++;
         m_step = 0;
         if (!m_busy) begin
            if (bus.run) begin m_busy = 1; m_mode = bus.mode; m_dwell = 0; end
         end else if (!bus.run) begin
            m_busy = 0;
         end else if (do_chk) begin
            case (m_mode)
               2'b00, 2'b01: m_pos = (m_pos + 1) % NP;
               2'b10:        m_cnt = m_cnt + 8'd1;
               default:      m_pos = (m_pos + 1) % (NP/2);
            endcase
            m_step  = 1;
            m_dwell = 0;
         end else begin
            m_dwell++;
         end
         m_sync2 = m_sync1;
         m_sync1 = m_cap;
      end
   endtask

   task automatic compare_model();
      logic [7:0] eo, eoe;
      model_pins(eo, eoe);
      chk("pin_out",   32'(bus.pin_out),   32'(eo));
      chk("pin_oe",    32'(bus.pin_oe),    32'(eoe));
      chk("pos",       32'(bus.pos),       32'(m_pos));
      chk("step",      32'(bus.step),      32'(m_step));
      chk("busy",      32'(bus.busy),      32'(m_busy));
      chk("err_flags", 32'(bus.err_flags), 32'(m_flags));
      chk("err_cnt",   32'(bus.err_cnt),   32'(m_errc));
   endtask

   // One clock: compare at the falling edge, advance model at the rising edge.
   task automatic tick();
      @(negedge gck);
      if (m_valid) compare_model();
      m_cap = bus.pin_in;
      @(posedge gck);
      model_step();
      #1;
   endtask

   task automatic wait_step(output int n);
      n = 0;
      for (int i = 0; i < 3*DWELL; i++) begin
         tick();
         n++;
         if (bus.step === 1'b1) return;
      end
      n_tests++;
      n_fail++;
      $display("FAIL step_timeout: got no step within %0d cycles, required a step", 3*DWELL);
   endtask

   logic [7:0] w1_tab [9];
   logic [7:0] w0_tab [4];

   initial begin
      int n;
      w1_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
      w0_tab = '{8'hFE, 8'hFD, 8'hFB, 8'hF7};
      gsr = 1'b1; stuck3 = 1'b0;
      bus.run = 1'b0; bus.mode = 2'b00; bus.clr_err = 1'b0;
      tick(); tick();
      gsr = 1'b0;
      tick();
      chk("reset_busy", 32'(bus.busy), 32'd0);
      chk("reset_oe",   32'(bus.pin_oe), 32'd0);
      chk("reset_pos",  32'(bus.pos), 32'd0);
      chk("reset_cnt",  32'(bus.err_cnt), 32'd0);

      // walk1
      bus.mode = 2'b00; bus.run = 1'b1;
      tick();
      chk("walk1_out0", 32'(bus.pin_out), 32'(w1_tab[0]));
      chk("walk1_oe",   32'(bus.pin_oe), 32'hFF);
      for (int i = 1; i <= 8; i++) begin
         wait_step(n);
         chk("walk1_out", 32'(bus.pin_out), 32'(w1_tab[i]));
         if (i > 1) chk("walk1_gap", 32'(n), 32'(DWELL));
      end
      bus.run = 1'b0;
      tick();

      // walk0, with a mode change while busy that must be ignored
      bus.mode = 2'b01; bus.run = 1'b1;
      tick();
      chk("walk0_out0", 32'(bus.pin_out), 32'(w0_tab[0]));
      bus.mode = 2'b10;
      for (int i = 1; i <= 3; i++) begin
         wait_step(n);
         chk("walk0_out", 32'(bus.pin_out), 32'(w0_tab[i]));
      end
      tick();
      bus.run = 1'b0;
      tick();
      chk("abort_busy", 32'(bus.busy), 32'd0);
      chk("abort_oe",   32'(bus.pin_oe), 32'd0);
      chk("abort_pos",  32'(bus.pos), 32'd3);

      // count from reset, including the 8-bit wrap
      gsr = 1'b1;
      tick();
      gsr = 1'b0; bus.mode = 2'b10; bus.run = 1'b1;
      tick();
      chk("count_out0", 32'(bus.pin_out), 32'h00);
      for (int i = 1; i <= 256; i++) begin
         wait_step(n);
         if (i <= 3)   chk("count_out", 32'(bus.pin_out), 32'(i));
         if (i == 255) chk("count_ff",  32'(bus.pin_out), 32'hFF);
         if (i == 256) chk("count_wrap", 32'(bus.pin_out), 32'h00);
      end

      // loopback, ideal jumpers
      bus.run = 1'b0; gsr = 1'b1;
      tick();
      gsr = 1'b0; bus.mode = 2'b11; bus.run = 1'b1;
      tick();
      chk("loop_oe", 32'(bus.pin_oe), 32'h55);
      for (int i = 0; i < 20; i++) wait_step(n);
      chk("loop_ideal_flags", 32'(bus.err_flags), 32'd0);
      chk("loop_ideal_cnt",   32'(bus.err_cnt), 32'd0);

      // loopback, pin 3 stuck low
      stuck3 = 1'b1;
      wait_step(n);
      wait_step(n);
      chk("stuck_flags", 32'(bus.err_flags), 32'h2);
      chk("stuck_cnt1",  32'(bus.err_cnt), 32'd1);
      for (int i = 0; i < 4; i++) wait_step(n);
      chk("stuck_cnt2",  32'(bus.err_cnt), 32'd2);
      for (int i = 0; i < 4; i++) wait_step(n);
      chk("stuck_cnt3",  32'(bus.err_cnt), 32'd3);
      for (int i = 0; i < 4; i++) wait_step(n);
      chk("stuck_sat",   32'(bus.err_cnt), 32'd3);

      // clr_err in a quiet cycle
      tick();
      bus.clr_err = 1'b1;
      tick();
      bus.clr_err = 1'b0;
      chk("clr_flags", 32'(bus.err_flags), 32'd0);
      chk("clr_cnt",   32'(bus.err_cnt), 32'd0);

      // clr_err coinciding with the failing CHECK of pos=1
      wait_step(n); wait_step(n); wait_step(n);
      chk("pre_clr_pos", 32'(bus.pos), 32'd1);
      for (int i = 0; i < DWELL-1; i++) tick();
      bus.clr_err = 1'b1;
      tick();
      bus.clr_err = 1'b0;
      chk("clrset_step",  32'(bus.step), 32'd1);
      chk("clrset_flags", 32'(bus.err_flags), 32'h2);
      chk("clrset_cnt",   32'(bus.err_cnt), 32'd1);

      // gsr during SETTLE1
      for (int i = 0; i < 4; i++) tick();
      gsr = 1'b1; bus.run = 1'b0;
      tick();
      chk("gsr_busy",  32'(bus.busy), 32'd0);
      chk("gsr_step",  32'(bus.step), 32'd0);
      chk("gsr_out",   32'(bus.pin_out), 32'd0);
      chk("gsr_oe",    32'(bus.pin_oe), 32'd0);
      chk("gsr_pos",   32'(bus.pos), 32'd0);
      chk("gsr_flags", 32'(bus.err_flags), 32'd0);
      chk("gsr_cnt",   32'(bus.err_cnt), 32'd0);
      gsr = 1'b0;
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
